axis_rr_packet_arbiter: RTL

Packet-granular round-robin arbiter that merges NUM_INPUTS AXI-Stream slave ports onto one master port. Its usual load is the input of axis_sync_fifo. A grant is held from the first beat of a packet until the tlast handshake, so packets are never interleaved. The winning source index is carried on tid, and a per-packet beat count is reported for downstream length bookkeeping.

---
 rtl/axis_rr_packet_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS AXI-Stream slaves onto one master.
// A grant is held from the first beat until the tlast handshake; the winner is reported on tid.
module axis_rr_packet_arbiter #(
    parameter int unsigned NUM_INPUTS       = 4,
    parameter int unsigned AXIS_TDATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH         = $clog2(NUM_INPUTS),
    parameter int unsigned BEAT_CNT_WIDTH   = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [NUM_INPUTS-1:0]                  i_s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]                  o_s_axis_tready,
    input  logic [NUM_INPUTS*AXIS_TDATA_WIDTH-1:0] i_s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]                  i_s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]                  i_s_axis_tuser,
    output logic                                   o_m_axis_tvalid,
    input  logic                                   i_m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]            o_m_axis_tdata,
    output logic                                   o_m_axis_tlast,
    output logic                                   o_m_axis_tuser,
    output logic [ID_WIDTH-1:0]                    o_m_axis_tid,
    output logic                                   o_busy,
    output logic                                   o_pkt_done,
    output logic [BEAT_CNT_WIDTH-1:0]              o_pkt_beats
);

    localparam logic [ID_WIDTH-1:0]       LAST_PORT = ID_WIDTH'(NUM_INPUTS - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [ID_WIDTH-1:0]         grant_q, grant_d;
    logic [ID_WIDTH-1:0]         last_grant_q, last_grant_d;
    logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BEAT_CNT_WIDTH-1:0]   pkt_beats_q, pkt_beats_d;
    logic                        pkt_done_q, pkt_done_d;

    logic [ID_WIDTH-1:0]         pick_hi, pick_lo, arb_pick;
    logic                        found_hi, found_lo, arb_found;
    logic                        sel_valid, sel_last, sel_user;
    logic [AXIS_TDATA_WIDTH-1:0] sel_data;
    logic [BEAT_CNT_WIDTH-1:0]   beat_inc;
    logic                        m_hs;

    // Round-robin search: ports above last_grant win first, then wrap to 0..last_grant.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned p = 0; p < NUM_INPUTS; p++) begin
            if (i_s_axis_tvalid[p]) begin
                if (p > 32'(last_grant_q)) begin
                    if (!found_hi) begin
                        pick_hi  = ID_WIDTH'(p);
                        found_hi = 1'b1;
                    end
                end else if (!found_lo) begin
                    pick_lo  = ID_WIDTH'(p);
                    found_lo = 1'b1;
                end
            end
        end
        arb_found = found_hi | found_lo;
        arb_pick  = found_hi ? pick_hi : pick_lo;
    end

    // Route the granted slave onto the internal selected bus.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_data  = '0;
        for (int unsigned p = 0; p < NUM_INPUTS; p++) begin
            if (grant_q == ID_WIDTH'(p)) begin
                sel_valid = i_s_axis_tvalid[p];
                sel_last  = i_s_axis_tlast[p];
                sel_user  = i_s_axis_tuser[p];
                sel_data  = i_s_axis_tdata[p*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            end
        end
    end

    assign m_hs     = (state_q == ST_BUSY) & sel_valid & i_m_axis_tready;
    assign beat_inc = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + BEAT_CNT_WIDTH'(1);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_found) state_d = ST_BUSY;
            ST_BUSY: if (m_hs && sel_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, priority pointer and packet length bookkeeping.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_beats_d  = pkt_beats_q;
        pkt_done_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (arb_found) grant_d = arb_pick;
        end else if (m_hs) begin
            if (sel_last) begin
                pkt_beats_d  = beat_inc;
                pkt_done_d   = 1'b1;
                beat_cnt_d   = '0;
                last_grant_d = grant_q;
            end else begin
                beat_cnt_d = beat_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_q      <= '0;
            last_grant_q <= LAST_PORT;
            beat_cnt_q   <= '0;
            pkt_beats_q  <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_beats_q  <= pkt_beats_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    // Output routing: zero-latency mux while busy, all quiet while idle.
    always_comb begin
        o_m_axis_tvalid = 1'b0;
        o_m_axis_tdata  = '0;
        o_m_axis_tlast  = 1'b0;
        o_m_axis_tuser  = 1'b0;
        o_m_axis_tid    = '0;
        o_s_axis_tready = '0;
        o_busy          = 1'b0;
        if (state_q == ST_BUSY) begin
            o_m_axis_tvalid = sel_valid;
            o_m_axis_tdata  = sel_data;
            o_m_axis_tlast  = sel_last;
            o_m_axis_tuser  = sel_user;
            o_m_axis_tid    = grant_q;
            o_busy          = 1'b1;
            for (int unsigned p = 0; p < NUM_INPUTS; p++) begin
                o_s_axis_tready[p] = (grant_q == ID_WIDTH'(p)) & i_m_axis_tready;
            end
        end
    end

    assign o_pkt_done  = pkt_done_q;
    assign o_pkt_beats = pkt_beats_q;

endmodule
